enemy_proj_engine: RTL and testbench
====================================

# enemy_proj_engine

Enemy projectile engine for the dodge game: owns a small pool of falling enemy projectiles, spawns them at pseudo-random X positions, and advances them once per game step. After each step it tests every projectile against the player's bounding box and issues a one-cycle `playerHit` pulse. It sits directly upstream of the player controller: that block consumes `playerHit` and supplies `playerX/Y/W/H` and `immune`. Projectile coordinates also feed the VGA renderer.

## Interface
Parameters:
- `NUM_PROJ`, 4 — projectile slots.
- `PROJ_W`, 10 — projectile width (px).
- `PROJ_H`, 10 — projectile height (px).
- `FALL_STEP`, 8 — Y increment per step.
- `SPAWN_PERIOD`, 6 — steps between spawn attempts (≥1).
- `TOP_Y`, 35 — spawn Y.
- `BOTTOM_Y`, 515 — despawn line.
- `LEFT_BOUNDARY`, 144 — left X bound.
- `RIGHT_BOUNDARY`, 784 — right X bound.
- `LFSR_SEED`, 16'hACE1 — non-zero LFSR seed.

Ports:
- `clk_master` in 1 — sole clock; all logic on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `pulse_stepCycle` in 1 — one-cycle game-step strobe.
- `enable` in 1 — 0 freezes the engine (game over / pause).
- `playerX` in 10 — player left edge.
- `playerY` in 9 — player top edge.
- `playerW` in 10 — player width.
- `playerH` in 9 — player height.
- `immune` in 1 — player is invulnerable.
- `playerHit` out 1 — registered one-cycle hit pulse.
- `projValid` out NUM_PROJ — slot occupied, bit i = slot i.
- `projX` out NUM_PROJ*10 — slot i at [10i+9:10i].
- `projY` out NUM_PROJ*10 — slot i at [10i+9:10i].

## Operation
- FSM states:
  - IDLE → MOVE when `pulse_stepCycle && enable`.
  - MOVE → SPAWN → CHECK.
  - CHECK takes NUM_PROJ cycles, one slot per cycle, index 0 first, then → IDLE.
- MOVE: each valid slot sets Y ← Y+FALL_STEP. If the new Y+PROJ_H ≥ BOTTOM_Y, the slot is cleared (valid←0, X,Y←0) in the same cycle. Arithmetic is 11-bit.
- SPAWN:
  - spawnCnt increments. On reaching SPAWN_PERIOD it resets to 0 and a spawn is attempted.
  - The lowest-index invalid slot loads Y=TOP_Y and X=LEFT_BOUNDARY+c, valid←1.
  - c = lfsr[9:0], minus R if ≥ R, where R = RIGHT_BOUNDARY−LEFT_BOUNDARY−PROJ_W (630 by default). One conditional subtract suffices because 1023−R < R.
  - All slots full: spawn dropped, counter still resets.
- CHECK, slot i overlaps when all four hold (11-bit compares, inputs zero-extended):
  - X < playerX+playerW
  - X+PROJ_W > playerX
  - Y < playerY+playerH
  - Y+PROJ_H > playerY
- Any overlapping slot is cleared.
- `playerHit` pulses on the cycle after the first overlap in the sweep, and only if `immune`=0 at the time of that compare. At most one hit per step; later overlaps in the same sweep clear silently.
- LFSR: 16-bit Galois, taps 16,14,13,11, advances every clock regardless of state or `enable`.
- `pulse_stepCycle` outside IDLE is ignored, not queued.
- `enable`=0 in IDLE: no state change, slots hold. Deasserting `enable` mid-sweep lets the sweep finish.

## Timing
- Reset values: `playerHit`=0, `projValid`=0, all `projX`/`projY`=0, state IDLE, spawnCnt=0, lfsr=LFSR_SEED.
- Step strobe at cycle t:
  - MOVE at t+1, SPAWN at t+2.
  - CHECK slot i at t+3+i.
  - `playerHit` high during t+4+i for first hitting slot i.
  - Back in IDLE at t+3+NUM_PROJ.
- Minimum step spacing is NUM_PROJ+3 cycles; `pulse_stepCycle` is far sparser in practice.
- Outputs are registered. Slot outputs update on the edge ending MOVE, SPAWN, or the slot's CHECK cycle.
- `rst` mid-sweep aborts immediately to reset values; `playerHit` is never emitted after reset assertion.

## Structure
- Shared package `game_pkg`:
  - FSM state enum (IDLE, MOVE, SPAWN, CHECK).
  - Screen bounds LEFT_BOUNDARY/RIGHT_BOUNDARY/TOP_Y/BOTTOM_Y.
  - Coordinate widths (X 10, Y 10).
  - Shared with the player controller and renderer.
- One sub-module, `lfsr16`, with ports clk_master, rst, seed and a 16-bit q output.
- Slot storage and the overlap comparator live in the top module. A single shared comparator is indexed by the sweep counter.

## Test plan
- Reset, then enable, then 6 step pulses: slot 0 valid after the 6th with Y=35 and 144 ≤ X ≤ 774; `playerHit` stays 0.
- Spawn with forced lfsr[9:0]=1000: X=144+(1000−630)=514.
- Slot at Y=500, one step: 508+10 ≥ 515, so the slot is cleared and `projValid[i]`=0 after MOVE.
- Player at (449,450,30,30), projectile placed so that after MOVE it sits at X=455, Y=445, `immune`=0: single `playerHit` pulse at t+4+i and the slot cleared. Repeat with `immune`=1: slot cleared, no pulse.
- Two slots overlapping the player in the same step: exactly one `playerHit` pulse, both slots cleared.
- All 4 slots full at a spawn step: spawn dropped and spawnCnt=0. Assert `rst` at t+3 mid-sweep: all outputs are 0 next cycle and no pulse follows.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, screen bounds and coordinate widths
package game_pkg;

  typedef enum logic [1:0] {IDLE, MOVE, SPAWN, CHECK} eng_state_t;

  localparam int X_W            = 10;
  localparam int Y_W            = 10;
  localparam int LEFT_BOUNDARY  = 144;
  localparam int RIGHT_BOUNDARY = 784;
  localparam int TOP_Y          = 35;
  localparam int BOTTOM_Y       = 515;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR, taps 16,14,13,11
module lfsr16 (
  input  logic        clk_master,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      q <= seed;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/enemy_proj_engine.sv
// rtl/enemy_proj_engine.sv - falling enemy projectile pool with spawn and player hit sweep
module enemy_proj_engine
  import game_pkg::*;
#(
  parameter int          NUM_PROJ       = 4,
  parameter int          PROJ_W         = 10,
  parameter int          PROJ_H         = 10,
  parameter int          FALL_STEP      = 8,
  parameter int          SPAWN_PERIOD   = 6,
  parameter int          TOP_Y          = game_pkg::TOP_Y,
  parameter int          BOTTOM_Y       = game_pkg::BOTTOM_Y,
  parameter int          LEFT_BOUNDARY  = game_pkg::LEFT_BOUNDARY,
  parameter int          RIGHT_BOUNDARY = game_pkg::RIGHT_BOUNDARY,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                    clk_master,
  input  logic                    rst,
  input  logic                    pulse_stepCycle,
  input  logic                    enable,
  input  logic [9:0]              playerX,
  input  logic [8:0]              playerY,
  input  logic [9:0]              playerW,
  input  logic [8:0]              playerH,
  input  logic                    immune,
  output logic                    playerHit,
  output logic [NUM_PROJ-1:0]     projValid,
  output logic [NUM_PROJ*X_W-1:0] projX,
  output logic [NUM_PROJ*Y_W-1:0] projY
);

  localparam int IDX_W = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1;
  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD + 1) : 1;
  localparam logic [9:0] SPAWN_RANGE = 10'(RIGHT_BOUNDARY - LEFT_BOUNDARY - PROJ_W);

  eng_state_t           state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     spawn_cnt;
  logic                 hit_done;
  logic [NUM_PROJ-1:0]  valid_q;
  logic [X_W-1:0]       x_q [NUM_PROJ];
  logic [Y_W-1:0]       y_q [NUM_PROJ];
  logic [10:0]          y_next [NUM_PROJ];

  logic [15:0]          lfsr_q;
  logic                 lfsr_unused;
  logic [9:0]           spawn_off;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;

  logic [10:0]          cx;
  logic [10:0]          cy;
  logic                 overlap;

  lfsr16 u_lfsr (
    .clk_master (clk_master),
    .rst        (rst),
    .seed       (LFSR_SEED),
    .q          (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:10];

  // 1023 - SPAWN_RANGE < SPAWN_RANGE, so a single subtract folds c into range
  assign spawn_off = (lfsr_q[9:0] >= SPAWN_RANGE) ? (lfsr_q[9:0] - SPAWN_RANGE) : lfsr_q[9:0];

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_PROJ - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PROJ; i++) begin
      y_next[i] = {1'b0, y_q[i]} + 11'(FALL_STEP);
    end
  end

  // Single comparator shared by the sweep, indexed by idx
  assign cx = {1'b0, x_q[idx]};
  assign cy = {1'b0, y_q[idx]};
  assign overlap = valid_q[idx]
                && (cx < ({1'b0, playerX} + {1'b0, playerW}))
                && ((cx + 11'(PROJ_W)) > {1'b0, playerX})
                && (cy < ({2'b0, playerY} + {2'b0, playerH}))
                && ((cy + 11'(PROJ_H)) > {2'b0, playerY});

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      spawn_cnt <= '0;
      hit_done  <= 1'b0;
      playerHit <= 1'b0;
      valid_q   <= '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      playerHit <= 1'b0;
      case (state)
        IDLE: begin
          if (pulse_stepCycle && enable) state <= MOVE;
        end
        MOVE: begin
          for (int i = 0; i < NUM_PROJ; i++) begin
            if (valid_q[i]) begin
              if ((y_next[i] + 11'(PROJ_H)) >= 11'(BOTTOM_Y)) begin
                valid_q[i] <= 1'b0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
              end else begin
                y_q[i] <= y_next[i][9:0];
              end
            end
          end
          state <= SPAWN;
        end
        SPAWN: begin
          if (spawn_cnt == CNT_W'(SPAWN_PERIOD - 1)) begin
            spawn_cnt <= '0;
            if (free_found) begin
              valid_q[free_idx] <= 1'b1;
              x_q[free_idx]     <= 10'(LEFT_BOUNDARY) + spawn_off;
              y_q[free_idx]     <= 10'(TOP_Y);
            end
          end else begin
            spawn_cnt <= spawn_cnt + CNT_W'(1);
          end
          idx      <= '0;
          hit_done <= 1'b0;
          state    <= CHECK;
        end
        CHECK: begin
          // Only the first overlap of a sweep may report a hit
          if (overlap) begin
            valid_q[idx] <= 1'b0;
            x_q[idx]     <= '0;
            y_q[idx]     <= '0;
            if (!hit_done) begin
              hit_done  <= 1'b1;
              playerHit <= !immune;
            end
          end
          if (idx == IDX_W'(NUM_PROJ - 1)) begin
            state <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign projValid = valid_q;

  for (genvar g = 0; g < NUM_PROJ; g++) begin : g_out
    assign projX[X_W*g +: X_W] = x_q[g];
    assign projY[Y_W*g +: Y_W] = y_q[g];
  end

endmodule

// File: tb/tb_enemy_proj_engine.sv
// tb/tb_enemy_proj_engine.sv - directed bench for enemy_proj_engine
module tb_enemy_proj_engine;

  localparam int NP = 4;

  logic          clk_master = 1'b0;
  logic          rst;
  logic          pulse_stepCycle;
  logic          enable;
  logic [9:0]    playerX;
  logic [8:0]    playerY;
  logic [9:0]    playerW;
  logic [8:0]    playerH;
  logic          immune;
  logic          playerHit;
  logic [NP-1:0] projValid;
  logic [NP*10-1:0] projX;
  logic [NP*10-1:0] projY;

  int checks = 0;
  int passes = 0;
  int hits;
  int hit_at;
  int total_hits = 0;
  int late_hits;
  logic [15:0] sl;
  logic [15:0] m_lfsr;
  logic [9:0]  xe [NP];

  enemy_proj_engine dut (
    .clk_master      (clk_master),
    .rst             (rst),
    .pulse_stepCycle (pulse_stepCycle),
    .enable          (enable),
    .playerX         (playerX),
    .playerY         (playerY),
    .playerW         (playerW),
    .playerH         (playerH),
    .immune          (immune),
    .playerHit       (playerHit),
    .projValid       (projValid),
    .projX           (projX),
    .projY           (projY)
  );

  always #5 clk_master = ~clk_master;

  // Reference Galois LFSR (mask 0xB400), free-running like the engine's
  always @(posedge clk_master or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  function automatic logic [9:0] exp_x(input logic [15:0] l);
    logic [9:0] c;
    c = l[9:0];
    if (c >= 10'd630) c = c - 10'd630;
    return 10'd144 + c;
  endfunction

  function automatic logic [9:0] slot_x(input int i);
    return projX[10*i +: 10];
  endfunction

  function automatic logic [9:0] slot_y(input int i);
    return projY[10*i +: 10];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  task automatic player_far();
    playerX = 10'd0; playerW = 10'd0; playerY = 9'd0; playerH = 9'd0; immune = 1'b0;
  endtask

  task automatic set_player(input int x, input int y, input int w, input int h, input bit imm);
    playerX = 10'(x); playerY = 9'(y); playerW = 10'(w); playerH = 9'(h); immune = imm;
  endtask

  // One game step; records hit count, the edge index (relative to the strobe)
  // at which playerHit was first seen, and the LFSR value during SPAWN
  task automatic step(input bit drop_en, input bit extra);
    @(negedge clk_master); pulse_stepCycle = 1'b1;
    @(negedge clk_master); pulse_stepCycle = 1'b0;
    if (drop_en) enable = 1'b0;
    @(negedge clk_master); sl = m_lfsr;
    hits = 0; hit_at = -1;
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk_master);
      if (playerHit === 1'b1) begin
        hits++;
        if (hit_at < 0) hit_at = k;
      end
      if (k == 3 && extra) pulse_stepCycle = 1'b1;
      if (k == 4) pulse_stepCycle = 1'b0;
    end
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; pulse_stepCycle = 1'b0; enable = 1'b0;
    player_far();
    repeat (3) @(negedge clk_master);
    chk("rst_hit", playerHit, 0);
    chk("rst_valid", projValid, 0);
    chk("rst_x", projX, 0);
    chk("rst_y", projY, 0);
    rst = 1'b0;

    // Strobe while disabled must not count as a step
    @(negedge clk_master); pulse_stepCycle = 1'b1;
    @(negedge clk_master); pulse_stepCycle = 1'b0;
    repeat (8) @(negedge clk_master);
    chk("disabled_valid", projValid, 0);
    enable = 1'b1;

    for (int s = 1; s <= 64; s++) begin
      step(1'b0, (s >= 7 && s <= 40));
      total_hits += hits;
      if (s % 6 == 0 && s <= 24) xe[s/6-1] = exp_x(sl);
      if (s == 5) chk("valid_step5", projValid, 0);
      if (s == 6) begin
        chk("valid_step6", projValid, 4'b0001);
        chk("y0_step6", slot_y(0), 35);
        chk("x0_step6", slot_x(0), xe[0]);
        chk("x0_range", (slot_x(0) >= 10'd144 && slot_x(0) <= 10'd774), 1);
      end
      if (s == 24) begin
        chk("valid_full", projValid, 4'b1111);
        chk("x_full", projX, {xe[3], xe[2], xe[1], xe[0]});
      end
      if (s == 36) begin
        chk("valid_dropped", projValid, 4'b1111);
        chk("x_dropped", projX, {xe[3], xe[2], xe[1], xe[0]});
      end
      if (s == 64) begin
        chk("y_step64", projY, {10'd355, 10'd403, 10'd451, 10'd499});
        chk("x_step64", projX, {xe[3], xe[2], xe[1], xe[0]});
      end
    end

    step(1'b0, 1'b0);  // 65: slot 0 reaches 507, 507+10 >= 515
    total_hits += hits;
    chk("valid_bottom", projValid, 4'b1110);
    chk("y0_bottom", slot_y(0), 0);
    chk("x0_bottom", slot_x(0), 0);

    step(1'b0, 1'b0);  // 66: spawn refills slot 0
    total_hits += hits;
    xe[0] = exp_x(sl);
    chk("valid_refill", projValid, 4'b1111);
    chk("x0_refill", slot_x(0), xe[0]);
    chk("y0_refill", slot_y(0), 35);
    chk("no_hits_so_far", total_hits, 0);

    set_player(xe[2], 427, 10, 10, 1'b0);  // 67: slot 2 lands at Y=427
    step(1'b0, 1'b0);
    chk("hit_count", hits, 1);
    chk("hit_cycle", hit_at, 6);
    chk("valid_after_hit", projValid, 4'b1011);
    chk("x2_after_hit", slot_x(2), 0);

    set_player(xe[3] - 30, 387, 30, 10, 1'b0);  // 68: right edge touches X exactly
    step(1'b0, 1'b0);
    chk("edge_hits", hits, 0);
    chk("edge_valid", projValid, 4'b1011);

    set_player(xe[3], 395, 10, 10, 1'b1);  // 69: immune overlap
    step(1'b0, 1'b0);
    chk("immune_hits", hits, 0);
    chk("immune_valid", projValid, 4'b0011);

    set_player(144, 60, 640, 460, 1'b0);  // 70: slots 0 and 1 both overlap
    step(1'b1, 1'b0);
    chk("double_hits", hits, 1);
    chk("double_cycle", hit_at, 4);
    chk("double_valid", projValid, 4'b0000);

    player_far();
    step(1'b0, 1'b0);  // 71
    step(1'b0, 1'b0);  // 72: spawn into slot 0
    xe[0] = exp_x(sl);
    chk("valid_s72", projValid, 4'b0001);
    chk("x0_s72", slot_x(0), xe[0]);

    // 73: reset during CHECK of slot 0, one cycle before the hit would register
    set_player(xe[0], 43, 10, 10, 1'b0);
    @(negedge clk_master); pulse_stepCycle = 1'b1;
    @(negedge clk_master); pulse_stepCycle = 1'b0;
    @(negedge clk_master);
    @(negedge clk_master); rst = 1'b1;
    #1;
    chk("rst_mid_valid", projValid, 0);
    chk("rst_mid_x", projX, 0);
    chk("rst_mid_y", projY, 0);
    late_hits = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_master);
      if (playerHit !== 1'b0) late_hits++;
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_master);
      if (playerHit !== 1'b0) late_hits++;
    end
    chk("rst_no_pulse", late_hits, 0);
    chk("rst_valid_after", projValid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
